// File: rtl/mix_columns_iter_if.sv
// Handshake bundle for the iterative MixColumns stage: an input state channel and an
// output state channel, each with its own valid/ready pair.
interface mix_columns_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, in_bypass, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_bypass, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mix_columns_iter.sv
// Iterative AES (Inv)MixColumns: one column per clock through a shared column multiplier,
// with a per-transaction bypass for the final round.
module mix_columns_iter #(
  parameter bit INVERSE = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  mix_columns_iter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StHold} state_e;

  state_e       state_q;
  logic [1:0]   col_q;
  logic [127:0] data_q;
  logic         in_ready_q;
  logic         out_valid_q;

  logic [31:0]  col_in;
  logic [31:0]  col_out;
  logic [127:0] data_mixed;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Constant multiplier (k < 16) built from the xtime chain x, 2x, 4x, 8x.
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? x : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  // Top matrix row applied to (p, q, r, s); the other rows reuse it with rotated inputs.
  function automatic logic [7:0] row_mix(input logic [7:0] p, input logic [7:0] q,
                                         input logic [7:0] r, input logic [7:0] s);
    if (INVERSE) begin
      return gf_mul(p, 4'he) ^ gf_mul(q, 4'hb) ^ gf_mul(r, 4'hd) ^ gf_mul(s, 4'h9);
    end
    return gf_mul(p, 4'h2) ^ gf_mul(q, 4'h3) ^ r ^ s;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {row_mix(a0, a1, a2, a3), row_mix(a1, a2, a3, a0),
            row_mix(a2, a3, a0, a1), row_mix(a3, a0, a1, a2)};
  endfunction

  always_comb begin
    col_in     = 32'h0;
    data_mixed = data_q;
    unique case (col_q)
      2'd0: col_in = data_q[127:96];
      2'd1: col_in = data_q[95:64];
      2'd2: col_in = data_q[63:32];
      2'd3: col_in = data_q[31:0];
      default: col_in = 32'h0;
    endcase
    col_out = mix_col(col_in);
    unique case (col_q)
      2'd0: data_mixed[127:96] = col_out;
      2'd1: data_mixed[95:64]  = col_out;
      2'd2: data_mixed[63:32]  = col_out;
      2'd3: data_mixed[31:0]   = col_out;
      default: data_mixed = data_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      col_q       <= 2'd0;
      data_q      <= 128'h0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            data_q     <= bus.in_data;
            in_ready_q <= 1'b0;
            col_q      <= 2'd0;
            if (bus.in_bypass) begin
              state_q     <= StHold;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          data_q <= data_mixed;
          col_q  <= col_q + 2'd1;
          if (col_q == 2'd3) begin
            state_q     <= StHold;
            out_valid_q <= 1'b1;
          end
        end
        StHold: begin
          if (bus.out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = data_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Self-checking bench for mix_columns_iter: forward and inverse instances checked against
// a GF(2^8) matrix-multiply reference model.
module tb_mix_columns_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mix_columns_iter_if bus0 ();
  mix_columns_iter_if bus1 ();

  mix_columns_iter #(.INVERSE(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mix_columns_iter #(.INVERSE(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // sel picks which instance the shared driver/observer talks to.
  logic         sel = 1'b0;
  logic         drv_valid = 1'b0;
  logic [127:0] drv_data = '0;
  logic         drv_bypass = 1'b0;
  logic         drv_oready = 1'b0;

  assign bus0.in_valid  = drv_valid & ~sel;
  assign bus0.in_data   = drv_data;
  assign bus0.in_bypass = drv_bypass;
  assign bus0.out_ready = drv_oready & ~sel;
  assign bus1.in_valid  = drv_valid & sel;
  assign bus1.in_data   = drv_data;
  assign bus1.in_bypass = drv_bypass;
  assign bus1.out_ready = drv_oready & sel;

  logic         obs_in_ready, obs_out_valid;
  logic [127:0] obs_out_data;
  assign obs_in_ready  = sel ? bus1.in_ready  : bus0.in_ready;
  assign obs_out_valid = sel ? bus1.out_valid : bus0.out_valid;
  assign obs_out_data  = sel ? bus1.out_data  : bus0.out_data;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    end
    return p;
  endfunction

  // out[c][r] = XOR_k coef[(k - r) mod 4] * in[c][k]
  function automatic logic [127:0] ref_mix(input bit inv, input logic [127:0] d);
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] res = '0;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc ^= gmul(coef[(k - r + 4) % 4], d[127 - 32*c - 8*k -: 8]);
        res[127 - 32*c - 8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  task automatic wait_in_ready(input string tag);
    int n = 0;
    while (!obs_in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check({tag, "_ready_timeout"}, 0, 1);
  endtask

  // One full transaction: accept, measure latency, check result, then complete the output.
  task automatic run_txn(input bit inv, input logic [127:0] d, input bit byp, input string tag);
    logic [127:0] exp;
    int lat = 0;
    bit busy_ok = 1'b1;
    sel = inv;
    exp = byp ? d : ref_mix(inv, d);
    wait_in_ready(tag);
    drv_data   = d;
    drv_bypass = byp;
    drv_valid  = 1'b1;
    @(posedge clk); #1;
    drv_valid  = 1'b0;
    drv_bypass = ~byp;
    drv_data   = {$urandom, $urandom, $urandom, $urandom};
    while (!obs_out_valid && lat < 20) begin
      if (obs_in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (obs_in_ready) busy_ok = 1'b0;
    check({tag, "_latency"}, lat, byp ? 0 : 4);
    check({tag, "_data"}, obs_out_data, exp);
    check({tag, "_in_ready_busy"}, busy_ok, 1);
    drv_oready = 1'b1;
    @(posedge clk); #1;
    drv_oready = 1'b0;
    check({tag, "_done_valid_ready"}, {obs_out_valid, obs_in_ready}, 2'b01);
  endtask

  localparam logic [127:0] VecPlain = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] VecMixed = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

  initial begin
    logic [127:0] d, exp, hold, other;
    logic [127:0] ins [3];
    logic [127:0] got [$];
    bit ok;
    int idx;
    bit acc;

    // Reset state of both instances.
    repeat (2) @(posedge clk);
    #1;
    sel = 1'b0;
    check("rst0_flags", {obs_out_valid, obs_in_ready}, 2'b01);
    check("rst0_data", obs_out_data, '0);
    sel = 1'b1;
    check("rst1_flags", {obs_out_valid, obs_in_ready}, 2'b01);
    check("rst1_data", obs_out_data, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reference model sanity against the known FIPS-197 column.
    check("model_fwd", ref_mix(1'b0, VecPlain), VecMixed);

    run_txn(1'b0, VecPlain, 1'b0, "vec_fwd");
    run_txn(1'b1, VecMixed, 1'b0, "vec_inv");
    run_txn(1'b0, 128'h00112233_44556677_8899aabb_ccddeeff, 1'b1, "vec_bypass");

    // Backpressure: output must stay put and a second state must not be taken.
    sel   = 1'b0;
    d     = {$urandom, $urandom, $urandom, $urandom};
    other = ~d;
    exp   = ref_mix(1'b0, d);
    wait_in_ready("bp");
    drv_data = d; drv_bypass = 1'b0; drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    idx = 0;
    while (!obs_out_valid && idx < 20) begin
      @(posedge clk); #1;
      idx++;
    end
    hold = obs_out_data;
    check("bp_data", hold, exp);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drv_valid  = (i == 1 || i == 2);
      drv_data   = other;
      drv_bypass = 1'b1;
      @(posedge clk); #1;
      if (!obs_out_valid || obs_out_data !== hold || obs_in_ready) ok = 1'b0;
    end
    drv_valid = 1'b0;
    check("bp_stable", ok, 1);
    drv_oready = 1'b1;
    @(posedge clk); #1;
    drv_oready = 1'b0;
    check("bp_release_flags", {obs_out_valid, obs_in_ready}, 2'b01);
    check("bp_no_second", obs_out_data, exp);

    // Randomised transactions on both polarities, occasionally bypassed.
    for (int i = 0; i < 8; i++) begin
      run_txn(i[0], {$urandom, $urandom, $urandom, $urandom}, ($urandom_range(0, 3) == 0),
              $sformatf("rand%0d", i));
    end

    // Asynchronous reset while the forward instance is at column 2.
    sel = 1'b0;
    wait_in_ready("rst_mid");
    drv_data = VecPlain; drv_bypass = 1'b0; drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_flags", {obs_out_valid, obs_in_ready}, 2'b01);
    check("rst_mid_data", obs_out_data, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_no_resume", {obs_out_valid, obs_in_ready}, 2'b01);
    run_txn(1'b0, {4{32'hdb135345}}, 1'b0, "post_rst");
    check("post_rst_model", ref_mix(1'b0, {4{32'hdb135345}}), {4{32'h8e4da1bc}});

    // Back-to-back stream with in_valid held and out_ready high.
    sel = 1'b0;
    for (int i = 0; i < 3; i++) ins[i] = {$urandom, $urandom, $urandom, $urandom};
    idx = 0;
    drv_oready = 1'b1;
    drv_bypass = 1'b0;
    drv_data   = ins[0];
    drv_valid  = 1'b1;
    for (int cyc = 0; cyc < 100 && got.size() < 3; cyc++) begin
      acc = obs_in_ready && drv_valid;
      if (obs_out_valid) got.push_back(obs_out_data);
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 3) drv_data = ins[idx];
        else drv_valid = 1'b0;
      end
    end
    drv_valid = 1'b0;
    ok = 1'b1;
    repeat (6) begin
      if (obs_out_valid) ok = 1'b0;
      @(posedge clk); #1;
    end
    drv_oready = 1'b0;
    check("stream_count", got.size(), 3);
    check("stream_no_extra", ok, 1);
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) check($sformatf("stream%0d", i), got[i], ref_mix(1'b0, ins[i]));
      else check($sformatf("stream%0d_missing", i), 0, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
